// File: rtl/pf_dispatch_engine.sv
// Prefetch dispatch engine: queues prefetch ops and expands each into a
// strided stream of line requests to the interleaved DC / L2 pipes.

// Per-pipe output lane: presents the current line on this pipe when the
// interleave bits select it; otherwise drives valid=0 and laddr=0.
module pf_dispatch_lane #(
  parameter int LADDR_W = 44
) (
  input  logic               hit,
  input  logic               dc_act,
  input  logic               l2_act,
  input  logic [LADDR_W-1:0] cur,
  output logic               dc_valid,
  output logic               l2_valid,
  output logic [LADDR_W-1:0] dc_laddr,
  output logic [LADDR_W-1:0] l2_laddr
);
  assign dc_valid = hit & dc_act;
  assign l2_valid = hit & l2_act;
  assign dc_laddr = dc_valid ? cur : '0;
  assign l2_laddr = l2_valid ? cur : '0;
endmodule

module pf_dispatch_engine #(
  parameter int NPIPE   = 2,
  parameter int LADDR_W = 44,
  parameter int QDEPTH  = 4,
  parameter int PAGE_LB = 6,
  parameter int TMO     = 15,
  parameter int STAT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     op_valid,
  output logic                     op_retry,
  input  logic [LADDR_W-1:0]       op_laddr,
  input  logic [7:0]               op_stride,
  input  logic [3:0]               op_degree,
  input  logic [1:0]               op_level,
  output logic [NPIPE-1:0]         dc_req_valid,
  input  logic [NPIPE-1:0]         dc_req_retry,
  output logic [NPIPE*LADDR_W-1:0] dc_req_laddr,
  output logic [NPIPE-1:0]         l2_req_valid,
  input  logic [NPIPE-1:0]         l2_req_retry,
  output logic [NPIPE*LADDR_W-1:0] l2_req_laddr,
  output logic [STAT_W-1:0]        stat_dc_issued,
  output logic [STAT_W-1:0]        stat_l2_issued,
  output logic [STAT_W-1:0]        stat_dropped,
  output logic [STAT_W-1:0]        stat_pgstop
);
  localparam int PB = (NPIPE > 1) ? $clog2(NPIPE) : 1;
  localparam int QW = $clog2(QDEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  localparam logic [QW:0] QFULL   = QDEPTH[QW:0];

  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic [7:0]         stride;
    logic [3:0]         degree;
    logic [1:0]         level;
  } pf_op_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  pf_op_t             q_mem [QDEPTH];
  pf_op_t             head;
  logic [QW-1:0]      wr_ptr, rd_ptr;
  logic [QW:0]        q_cnt, q_cnt_nxt;
  logic               push, pop;

  state_t             state, state_nxt;
  logic [LADDR_W-1:0] cur, cur_nxt, nxt;
  logic [3:0]         rem, rem_nxt;
  logic [1:0]         lvl, lvl_nxt;
  logic [7:0]         stride, stride_nxt;
  logic               dc_done, l2_done, dc_done_nxt, l2_done_nxt;
  logic [7:0]         dc_wait, l2_wait, dc_wait_nxt, l2_wait_nxt;
  logic               dc_act, l2_act, dc_rty, l2_rty;
  logic               dc_xfer, l2_xfer, dc_tmo, l2_tmo;
  logic               all_done, pg_cross, pg_inc;
  logic [PB-1:0]      pidx;

  logic [NPIPE-1:0][LADDR_W-1:0] dc_laddr_arr, l2_laddr_arr;

  // Queue bookkeeping; a full queue refuses pushes even if a pop is underway
  assign head      = q_mem[rd_ptr];
  assign push      = op_valid & ~op_retry & ~flush;
  assign pop       = (state == IDLE) & (q_cnt != '0) & ~flush;
  assign q_cnt_nxt = q_cnt + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};

  // Queue storage carries no reset; only pointers/count define occupancy
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{op_laddr, op_stride, op_degree, op_level};
  end

  // Queue pointers, occupancy and the registered full indication
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0; rd_ptr <= '0; q_cnt <= '0; op_retry <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0; rd_ptr <= '0; q_cnt <= '0; op_retry <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      q_cnt    <= q_cnt_nxt;
      op_retry <= (q_cnt_nxt == QFULL);
    end
  end

  // Target handshake state for the line currently in flight
  assign pidx     = (NPIPE > 1) ? cur[PB-1:0] : '0;
  assign dc_act   = (state == ISSUE) & lvl[0] & ~dc_done;
  assign l2_act   = (state == ISSUE) & lvl[1] & ~l2_done;
  assign dc_rty   = dc_act & dc_req_retry[pidx];
  assign l2_rty   = l2_act & l2_req_retry[pidx];
  assign dc_xfer  = dc_act & ~dc_req_retry[pidx];
  assign l2_xfer  = l2_act & ~l2_req_retry[pidx];
  assign dc_tmo   = dc_rty & (dc_wait == TMO_LAST);
  assign l2_tmo   = l2_rty & (l2_wait == TMO_LAST);
  assign nxt      = cur + {{(LADDR_W-8){stride[7]}}, stride};
  assign pg_cross = nxt[LADDR_W-1:PAGE_LB] != cur[LADDR_W-1:PAGE_LB];

  // Next-state: load ops in IDLE, walk the stride in ISSUE, flush wins
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    rem_nxt     = rem;
    lvl_nxt     = lvl;
    stride_nxt  = stride;
    dc_done_nxt = dc_done | dc_xfer | dc_tmo;
    l2_done_nxt = l2_done | l2_xfer | l2_tmo;
    dc_wait_nxt = dc_rty ? dc_wait + 8'd1 : dc_wait;
    l2_wait_nxt = l2_rty ? l2_wait + 8'd1 : l2_wait;
    pg_inc      = 1'b0;
    all_done    = (~lvl[0] | dc_done_nxt) & (~lvl[1] | l2_done_nxt);
    case (state)
      IDLE: begin
        if (pop) begin
          cur_nxt     = head.laddr;
          rem_nxt     = head.degree;
          lvl_nxt     = head.level;
          stride_nxt  = head.stride;
          dc_done_nxt = 1'b0; l2_done_nxt = 1'b0;
          dc_wait_nxt = '0;   l2_wait_nxt = '0;
          if (head.degree != 4'd0 && head.level != 2'b00) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (all_done) begin
          rem_nxt     = rem - 4'd1;
          dc_done_nxt = 1'b0; l2_done_nxt = 1'b0;
          dc_wait_nxt = '0;   l2_wait_nxt = '0;
          if (rem_nxt == 4'd0 || stride == 8'd0) begin
            state_nxt = IDLE;
          end else if (pg_cross) begin
            state_nxt = IDLE;
            pg_inc    = 1'b1;
          end else begin
            cur_nxt = nxt;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt   = IDLE;
      dc_done_nxt = 1'b0; l2_done_nxt = 1'b0;
      dc_wait_nxt = '0;   l2_wait_nxt = '0;
      pg_inc      = 1'b0;
    end
  end

  // FSM and current-op registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE; cur <= '0; rem <= '0; lvl <= '0; stride <= '0;
      dc_done <= 1'b0; l2_done <= 1'b0; dc_wait <= '0; l2_wait <= '0;
    end else begin
      state <= state_nxt; cur <= cur_nxt; rem <= rem_nxt; lvl <= lvl_nxt;
      stride <= stride_nxt; dc_done <= dc_done_nxt; l2_done <= l2_done_nxt;
      dc_wait <= dc_wait_nxt; l2_wait <= l2_wait_nxt;
    end
  end

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  // Saturating stats; transfers coinciding with a flush are aborted, not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_dc_issued <= '0; stat_l2_issued <= '0; stat_dropped <= '0; stat_pgstop <= '0;
    end else begin
      stat_dc_issued <= sat_inc(stat_dc_issued, dc_xfer & ~flush);
      stat_l2_issued <= sat_inc(stat_l2_issued, l2_xfer & ~flush);
      stat_dropped   <= sat_inc(sat_inc(stat_dropped, dc_tmo & ~flush), l2_tmo & ~flush);
      stat_pgstop    <= sat_inc(stat_pgstop, pg_inc);
    end
  end

  for (genvar p = 0; p < NPIPE; p++) begin : g_lane
    pf_dispatch_lane #(.LADDR_W(LADDR_W)) u_lane (
      .hit      (pidx == PB'(p)),
      .dc_act   (dc_act),
      .l2_act   (l2_act),
      .cur      (cur),
      .dc_valid (dc_req_valid[p]),
      .l2_valid (l2_req_valid[p]),
      .dc_laddr (dc_laddr_arr[p]),
      .l2_laddr (l2_laddr_arr[p])
    );
  end

  assign dc_req_laddr = dc_laddr_arr;
  assign l2_req_laddr = l2_laddr_arr;
endmodule

// File: tb/tb_pf_dispatch_engine.sv
// Directed bench for pf_dispatch_engine (NPIPE=2, 16-bit line address, 4-bit stats).
module tb_pf_dispatch_engine;
  logic        clk, reset, flush, op_valid, op_retry;
  logic [15:0] op_laddr;
  logic [7:0]  op_stride;
  logic [3:0]  op_degree;
  logic [1:0]  op_level;
  logic [1:0]  dc_req_valid, dc_req_retry, l2_req_valid, l2_req_retry;
  logic [31:0] dc_req_laddr, l2_req_laddr;
  logic [3:0]  stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop;
  int checks = 0;
  int errors = 0;

  pf_dispatch_engine #(.NPIPE(2), .LADDR_W(16), .QDEPTH(4), .PAGE_LB(6), .TMO(15), .STAT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op_retry(op_retry),
    .op_laddr(op_laddr), .op_stride(op_stride), .op_degree(op_degree), .op_level(op_level),
    .dc_req_valid(dc_req_valid), .dc_req_retry(dc_req_retry), .dc_req_laddr(dc_req_laddr),
    .l2_req_valid(l2_req_valid), .l2_req_retry(l2_req_retry), .l2_req_laddr(l2_req_laddr),
    .stat_dc_issued(stat_dc_issued), .stat_l2_issued(stat_l2_issued),
    .stat_dropped(stat_dropped), .stat_pgstop(stat_pgstop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled on negedges; inputs change right after sampling.
  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; op_valid = 1'b0;
    dc_req_retry = 2'b00; l2_req_retry = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_op(input logic [15:0] a, input logic [7:0] s, input logic [3:0] d, input logic [1:0] l);
    op_valid = 1'b1; op_laddr = a; op_stride = s; op_degree = d; op_level = l;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; op_valid = 1'b0;
    dc_req_retry = 2'b00; l2_req_retry = 2'b00;
    op_laddr = '0; op_stride = '0; op_degree = '0; op_level = '0;
    @(negedge clk);
    checks++;
    if ({dc_req_valid, l2_req_valid, op_retry} !== 5'b0 || {dc_req_laddr, l2_req_laddr} !== 64'h0 ||
        {stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state valid=%b/%b retry=%b laddr=%h/%h stats=%h want all 0",
               dc_req_valid, l2_req_valid, op_retry, dc_req_laddr, l2_req_laddr,
               {stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dc_req_valid, l2_req_valid, op_retry} !== 5'b0) begin
      errors++; $display("FAIL idle_after_reset valid=%b/%b retry=%b want 0", dc_req_valid, l2_req_valid, op_retry);
    end
  endtask

  task automatic test_stride_dc();
    logic [1:0]  ev;
    logic [31:0] ea;
    do_reset();
    set_op(16'h0100, 8'd1, 4'd4, 2'b01);
    @(negedge clk); op_valid = 1'b0;
    checks++;
    if (dc_req_valid !== 2'b00) begin
      errors++; $display("FAIL t1_latency valid=%b at N+1 want 00", dc_req_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ev = 2'b01 << (i % 2);
      ea = 32'(16'h0100 + 16'(i)) << (16 * (i % 2));
      checks++;
      if (dc_req_valid !== ev || dc_req_laddr !== ea || l2_req_valid !== 2'b00) begin
        errors++;
        $display("FAIL t1_line%0d valid=%b laddr=%h l2v=%b want valid=%b laddr=%h l2v=00",
                 i, dc_req_valid, dc_req_laddr, l2_req_valid, ev, ea);
      end
    end
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b00 || stat_dc_issued !== 4'd4 || stat_l2_issued !== 4'd0) begin
      errors++;
      $display("FAIL t1_end valid=%b dc_issued=%0d l2_issued=%0d want 00 4 0", dc_req_valid, stat_dc_issued, stat_l2_issued);
    end
  endtask

  task automatic test_page_stop();
    do_reset();
    set_op(16'h013E, 8'd1, 4'd5, 2'b10);
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 2'b01 || l2_req_laddr !== 32'h0000_013E || dc_req_valid !== 2'b00) begin
      errors++; $display("FAIL t2_line0 l2v=%b laddr=%h dcv=%b want 01 0000013e 00", l2_req_valid, l2_req_laddr, dc_req_valid);
    end
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 2'b10 || l2_req_laddr !== 32'h013F_0000) begin
      errors++; $display("FAIL t2_line1 l2v=%b laddr=%h want 10 013f0000", l2_req_valid, l2_req_laddr);
    end
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 2'b00 || stat_pgstop !== 4'd1 || stat_l2_issued !== 4'd2) begin
      errors++; $display("FAIL t2_stop l2v=%b pgstop=%0d l2_issued=%0d want 00 1 2", l2_req_valid, stat_pgstop, stat_l2_issued);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (l2_req_valid !== 2'b00 || dc_req_valid !== 2'b00) begin
      errors++; $display("FAIL t2_idle l2v=%b dcv=%b want 00 00", l2_req_valid, dc_req_valid);
    end
  endtask

  task automatic test_split_retry();
    do_reset();
    set_op(16'h0200, 8'd1, 4'd1, 2'b11);
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b01 || l2_req_valid !== 2'b01 || dc_req_laddr !== 32'h0200 || l2_req_laddr !== 32'h0200) begin
      errors++; $display("FAIL t3_cycle1 dcv=%b l2v=%b dca=%h l2a=%h want 01 01 200 200",
                         dc_req_valid, l2_req_valid, dc_req_laddr, l2_req_laddr);
    end
    dc_req_retry = 2'b01;
    set_op(16'h0210, 8'd1, 4'd1, 2'b01);
    @(negedge clk); op_valid = 1'b0;
    checks++;
    if (dc_req_valid !== 2'b01 || l2_req_valid !== 2'b00 || dc_req_laddr !== 32'h0200) begin
      errors++; $display("FAIL t3_indep dcv=%b l2v=%b dca=%h want 01 00 200", dc_req_valid, l2_req_valid, dc_req_laddr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b01 || dc_req_laddr !== 32'h0200) begin
      errors++; $display("FAIL t3_cycle4 dcv=%b dca=%h want 01 200", dc_req_valid, dc_req_laddr);
    end
    dc_req_retry = 2'b00;
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b00 || l2_req_valid !== 2'b00 || stat_dc_issued !== 4'd1 || stat_l2_issued !== 4'd1) begin
      errors++; $display("FAIL t3_done dcv=%b l2v=%b dc=%0d l2=%0d want 00 00 1 1",
                         dc_req_valid, l2_req_valid, stat_dc_issued, stat_l2_issued);
    end
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b01 || dc_req_laddr !== 32'h0210) begin
      errors++; $display("FAIL t3_next_op dcv=%b dca=%h want 01 210", dc_req_valid, dc_req_laddr);
    end
  endtask

  task automatic test_timeout();
    int held = 0;
    do_reset();
    dc_req_retry = 2'b10;
    set_op(16'h0301, 8'hFF, 4'd2, 2'b01);
    @(negedge clk); op_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dc_req_valid == 2'b10 && dc_req_laddr == 32'h0301_0000) held++;
    end
    checks++;
    if (held !== 15) begin
      errors++; $display("FAIL t4_hold cycles=%0d want 15", held);
    end
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b01 || dc_req_laddr !== 32'h0000_0300 || stat_dropped !== 4'd1) begin
      errors++; $display("FAIL t4_next dcv=%b dca=%h dropped=%0d want 01 00000300 1", dc_req_valid, dc_req_laddr, stat_dropped);
    end
    @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b00 || stat_dc_issued !== 4'd1 || stat_dropped !== 4'd1) begin
      errors++; $display("FAIL t4_end dcv=%b dc=%0d dropped=%0d want 00 1 1", dc_req_valid, stat_dc_issued, stat_dropped);
    end
    dc_req_retry = 2'b00;
  endtask

  task automatic test_queue_full_flush();
    int early_full = 0;
    do_reset();
    dc_req_retry = 2'b11; l2_req_retry = 2'b11;
    for (int i = 0; i < 5; i++) begin
      if (op_retry !== 1'b0) early_full++;
      set_op(16'h0400 + 16'(i), 8'd1, 4'd1, 2'b01);
      @(negedge clk);
    end
    op_valid = 1'b0;
    checks++;
    if (early_full !== 0 || op_retry !== 1'b1) begin
      errors++; $display("FAIL t5_full early=%0d retry=%b want 0 1", early_full, op_retry);
    end
    set_op(16'h0480, 8'd1, 4'd1, 2'b01);
    @(negedge clk);
    checks++;
    if (op_retry !== 1'b1 || dc_req_valid !== 2'b01 || dc_req_laddr !== 32'h0400) begin
      errors++; $display("FAIL t5_refuse retry=%b dcv=%b dca=%h want 1 01 400", op_retry, dc_req_valid, dc_req_laddr);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    checks++;
    if (op_retry !== 1'b0 || dc_req_valid !== 2'b00 || l2_req_valid !== 2'b00) begin
      errors++; $display("FAIL t5_flush retry=%b dcv=%b l2v=%b want 0 00 00", op_retry, dc_req_valid, l2_req_valid);
    end
    dc_req_retry = 2'b00; l2_req_retry = 2'b00;
    repeat (4) @(negedge clk);
    checks++;
    if (dc_req_valid !== 2'b00 || stat_dc_issued !== 4'd0 || stat_dropped !== 4'd0) begin
      errors++; $display("FAIL t5_empty dcv=%b dc=%0d dropped=%0d want 00 0 0", dc_req_valid, stat_dc_issued, stat_dropped);
    end
  endtask

  task automatic test_discard();
    int seen = 0;
    do_reset();
    set_op(16'h0700, 8'd1, 4'd0, 2'b01);
    @(negedge clk);
    set_op(16'h0710, 8'd1, 4'd2, 2'b00);
    @(negedge clk); op_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dc_req_valid != 2'b00 || l2_req_valid != 2'b00) seen++;
    end
    checks++;
    if (seen !== 0 || {stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop} !== 16'h0) begin
      errors++; $display("FAIL discard valid_cycles=%0d stats=%h want 0 0000", seen,
                         {stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop});
    end
    set_op(16'h0721, 8'd1, 4'd1, 2'b10);
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 2'b10 || l2_req_laddr !== 32'h0721_0000) begin
      errors++; $display("FAIL discard_then_op l2v=%b l2a=%h want 10 07210000", l2_req_valid, l2_req_laddr);
    end
  endtask

  task automatic test_reset_mid_and_saturate();
    int lines = 0;
    do_reset();
    set_op(16'h0500, 8'd1, 4'd8, 2'b01);
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({dc_req_valid, l2_req_valid, op_retry} !== 5'b0 || dc_req_laddr !== 32'h0 ||
        {stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop} !== 16'h0) begin
      errors++; $display("FAIL t6_reset dcv=%b l2v=%b retry=%b dca=%h stats=%h want all 0",
                         dc_req_valid, l2_req_valid, op_retry, dc_req_laddr,
                         {stat_dc_issued, stat_l2_issued, stat_dropped, stat_pgstop});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_op(16'h0600, 8'd1, 4'd10, 2'b01);
    @(negedge clk);
    set_op(16'h0610, 8'd1, 4'd10, 2'b01);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      if (dc_req_valid != 2'b00) lines++;
    end
    checks++;
    if (lines !== 20) begin
      errors++; $display("FAIL t6_lines observed=%0d want 20", lines);
    end
    checks++;
    if (stat_dc_issued !== 4'd15) begin
      errors++; $display("FAIL t6_saturate dc_issued=%0d want 15", stat_dc_issued);
    end
  endtask

  initial begin
    test_reset();
    test_stride_dc();
    test_page_stop();
    test_split_retry();
    test_timeout();
    test_queue_full_flush();
    test_discard();
    test_reset_mid_and_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
